// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data memory access sequencer.
// Latches one load/store from EX/MEM and runs it on a req/ack
// memory port. It stalls the front of the pipe while the access
// is outstanding and hands load data to MEM/WB.
// Ports: clk, rst (sync, active-high);
//   EX/MEM side: mem_read, mem_write, addr_in, wdata_in;
//   memory side: mem_req, mem_we, mem_addr, mem_wdata, mem_ack, mem_rdata;
//   pipeline side: stall, rdata_out, rdata_valid, err.
// Optional macro MEM_TIMEOUT_EN adds an ACCESS cycle counter. When it
// reaches TIMEOUT_CYCLES, the access is aborted and err is set (sticky).
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr_in,
   input  logic [31:0] wdata_in,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        stall,
   output logic [31:0] rdata_out,
   output logic        rdata_valid,
   output logic        err
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
      $error("TIMEOUT_CYCLES must be in 1..255");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rvalid_q, rvalid_d;

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
`endif

   // DONE is a bubble: EX/MEM advances there, so the new
   // instruction must not be taken until the next IDLE cycle.
   always_comb begin
      state_d     = state_q;
      mem_req_d   = 1'b0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      rvalid_d    = 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_d       = cnt_q;
      err_d       = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (mem_read || mem_write) begin
               state_d     = ACCESS;
               mem_req_d   = 1'b1;
               mem_we_d    = mem_write;
               mem_addr_d  = addr_in;
               mem_wdata_d = wdata_in;
`ifdef MEM_TIMEOUT_EN
               cnt_d       = 8'd0;
`endif
            end
         end
         ACCESS: begin
            if (mem_ack) begin
               state_d = DONE;
               if (!mem_we_q) begin
                  rdata_d  = mem_rdata;
                  rvalid_d = 1'b1;
               end
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               // Abort: loads still get a (zero) result so WB retires.
               state_d  = DONE;
               err_d    = 1'b1;
               rdata_d  = 32'd0;
               rvalid_d = !mem_we_q;
            end else begin
               mem_req_d = 1'b1;
               cnt_d     = cnt_q + 8'd1;
            end
`else
            else begin
               mem_req_d = 1'b1;
            end
`endif
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         rdata_q     <= 32'd0;
         rvalid_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         cnt_q       <= 8'd0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q       <= cnt_d;
         err_q       <= err_d;
`endif
      end
   end

   assign stall = (state_q == ACCESS) ||
                  ((state_q == IDLE) && (mem_read || mem_write));

   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign rdata_out   = rdata_q;
   assign rdata_valid = rvalid_q;

`ifdef MEM_TIMEOUT_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: transaction-level expectations,
// per-cycle compare at negedge, randomized accesses.
module tb_mem_access_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [31:0] addr_in, wdata_in;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        stall;
   logic [31:0] rdata_out;
   logic        rdata_valid;
   logic        err;

   mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write),
      .addr_in(addr_in), .wdata_in(wdata_in),
      .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .stall(stall), .rdata_out(rdata_out),
      .rdata_valid(rdata_valid), .err(err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 0;

   // Expected outputs for the current cycle.
   logic        e_stall, e_req, e_we, e_valid, e_err;
   logic [31:0] e_addr, e_wdata, e_rdata;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall", 32'(stall), 32'(e_stall));
         chk("mem_req", 32'(mem_req), 32'(e_req));
         chk("mem_we", 32'(mem_we), 32'(e_we));
         chk("mem_addr", mem_addr, e_addr);
         chk("mem_wdata", mem_wdata, e_wdata);
         chk("rdata_out", rdata_out, e_rdata);
         chk("rdata_valid", 32'(rdata_valid), 32'(e_valid));
         chk("err", 32'(err), 32'(e_err));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      addr_in   = $urandom;
      wdata_in  = $urandom;
      mem_ack   = 1'($urandom);
      mem_rdata = $urandom;
      e_stall   = 1'b0;
      e_req     = 1'b0;
      e_valid   = 1'b0;
   endtask

   // One access: request cycle, (waits+1) ACCESS cycles, one DONE cycle.
   // Returns how many cycles stall / mem_req / rdata_valid were seen high.
   task automatic access(input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input int waits, input logic [31:0] rdat,
                         input bit spur,
                         output int sc, output int rc, output int vc);
      int  nacc;
      bit  to;
      bit  isr;
      nacc = waits + 1;
      to   = 1'b0;
      isr  = !wr;
      sc = 0; rc = 0; vc = 0;
`ifdef MEM_TIMEOUT_EN
      if (nacc > TO) begin
         nacc = TO;
         to   = 1'b1;
      end
`endif
      step();
      mem_read  = rd;
      mem_write = wr;
      addr_in   = a;
      wdata_in  = d;
      mem_ack   = spur;
      mem_rdata = $urandom;
      e_stall   = 1'b1;
      e_req     = 1'b0;
      e_valid   = 1'b0;
      @(negedge clk);
      sc += int'(stall); rc += int'(mem_req); vc += int'(rdata_valid);
      for (int k = 1; k <= nacc; k++) begin
         step();
         addr_in   = $urandom;
         wdata_in  = $urandom;
         mem_ack   = (k == nacc) && !to;
         mem_rdata = ((k == nacc) && !to) ? rdat : $urandom;
         e_stall   = 1'b1;
         e_req     = 1'b1;
         e_we      = wr;
         e_addr    = a;
         e_wdata   = d;
         e_valid   = 1'b0;
         @(negedge clk);
         sc += int'(stall); rc += int'(mem_req); vc += int'(rdata_valid);
      end
      step();
      mem_read  = 1'($urandom);
      mem_write = 1'($urandom);
      addr_in   = $urandom;
      mem_ack   = 1'($urandom);
      mem_rdata = $urandom;
      e_stall   = 1'b0;
      e_req     = 1'b0;
      e_valid   = isr;
      if (to) begin
         e_err   = 1'b1;
         e_rdata = 32'd0;
      end else if (isr) begin
         e_rdata = rdat;
      end
      @(negedge clk);
      sc += int'(stall); rc += int'(mem_req); vc += int'(rdata_valid);
   endtask

   task automatic set_reset_exp();
      e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0; e_valid = 1'b0;
      e_err = 1'b0; e_addr = 32'd0; e_wdata = 32'd0; e_rdata = 32'd0;
   endtask

   initial begin
      int sc, rc, vc;
      bit rd, wr;
      rst = 1'b1;
      mem_read = 0; mem_write = 0; addr_in = 0; wdata_in = 0;
      mem_ack = 0; mem_rdata = 0;
      set_reset_exp();
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      idle();

      // Load with immediate ack.
      access(1, 0, 32'h10, 32'h0, 0, 32'hCAFE0001, 0, sc, rc, vc);
      chk("load_stall_cycles", 32'(sc), 32'd2);
      chk("load_req_cycles", 32'(rc), 32'd1);
      chk("load_valid_cycles", 32'(vc), 32'd1);
      chk("load_rdata_pin", rdata_out, 32'hCAFE0001);
      idle();

      // Store with 3 wait cycles.
      access(0, 1, 32'h20, 32'h12345678, 3, 32'hDEAD0000, 0, sc, rc, vc);
      chk("store_stall_cycles", 32'(sc), 32'd5);
      chk("store_req_cycles", 32'(rc), 32'd4);
      chk("store_valid_cycles", 32'(vc), 32'd0);
      chk("store_rdata_hold", rdata_out, 32'hCAFE0001);

      // Back-to-back load then store, no gap.
      access(1, 0, 32'h30, 32'h0, 0, 32'h0BADF00D, 0, sc, rc, vc);
      access(0, 1, 32'h34, 32'h55AA55AA, 0, 32'h0, 0, sc, rc, vc);
      chk("b2b_req_cycles", 32'(rc), 32'd1);
      idle();
      idle();

      // Read+write together with spurious ack in IDLE -> write.
      access(1, 1, 32'h40, 32'hA5A5A5A5, 1, 32'h11111111, 1, sc, rc, vc);
      chk("rw_valid_cycles", 32'(vc), 32'd0);
      chk("rw_we_pin", 32'(mem_we), 32'd1);
      idle();

      // Reset during second ACCESS cycle.
      step();
      mem_read = 1; mem_write = 0; addr_in = 32'h50; mem_ack = 0;
      e_stall = 1; e_req = 0; e_valid = 0;
      step();
      e_stall = 1; e_req = 1; e_we = 0; e_addr = 32'h50; e_wdata = wdata_in;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      mem_read = 0; mem_write = 0;
      set_reset_exp();
      @(negedge clk);
      chk("rst_addr_pin", mem_addr, 32'd0);
      chk("rst_req_pin", 32'(mem_req), 32'd0);

`ifdef MEM_TIMEOUT_EN
      access(1, 0, 32'h60, 32'h0, 20, 32'h0, 0, sc, rc, vc);
      chk("to_req_cycles", 32'(rc), 32'(TO));
      chk("to_err_pin", 32'(err), 32'd1);
      chk("to_rdata_pin", rdata_out, 32'd0);
      chk("to_valid_cycles", 32'(vc), 32'd1);
      idle();
      access(1, 0, 32'h64, 32'h0, 0, 32'h77, 0, sc, rc, vc);
      chk("to_err_sticky", 32'(err), 32'd1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      mem_read = 0; mem_write = 0;
      set_reset_exp();
`endif

      // Randomized traffic.
      for (int n = 0; n < 60; n++) begin
         rd = 1'($urandom);
         wr = 1'($urandom);
         if (!rd && !wr) rd = 1'b1;
         access(rd, wr, $urandom, $urandom, int'($urandom_range(0, 5)),
                $urandom, 1'($urandom), sc, rc, vc);
         repeat ($urandom_range(0, 2)) idle();
      end
      idle();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15: number of ACCESS cycles without mem_ack before abort; legal range 1..255.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port mem_read, input, 1 bit: memory read control from the EX/MEM register.
REQ-005 SHALL have port mem_write, input, 1 bit: memory write control from the EX/MEM register.
REQ-006 SHALL have port addr_in, input, 32 bits: ALU result from EX/MEM, used as byte address.
REQ-007 SHALL have port wdata_in, input, 32 bits: store data from EX/MEM.
REQ-008 SHALL have port mem_req, output, 1 bit: request to data memory.
REQ-009 SHALL have port mem_we, output, 1 bit: write enable qualifying mem_req.
REQ-010 SHALL have port mem_addr, output, 32 bits: latched access address.
REQ-011 SHALL have port mem_wdata, output, 32 bits: latched store data.
REQ-012 SHALL have port mem_ack, input, 1 bit: memory completion, one-cycle pulse.
REQ-013 SHALL have port mem_rdata, input, 32 bits: read data, valid while mem_ack=1.
REQ-014 SHALL have port stall, output, 1 bit: freezes PC, IF/ID, ID/EX and EX/MEM when high.
REQ-015 SHALL have port rdata_out, output, 32 bits: captured load data for MEM/WB.
REQ-016 SHALL have port rdata_valid, output, 1 bit: one-cycle pulse marking rdata_out as new.
REQ-017 SHALL have port err, output, 1 bit: sticky timeout flag.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-019 In IDLE with mem_read or mem_write high, SHALL latch addr_in, wdata_in and mem_we=mem_write, and SHALL enter ACCESS on the next cycle.
REQ-020 When mem_read and mem_write are both high, SHALL treat the access as a write (mem_we=1).
REQ-021 stall SHALL be combinational: high when state is IDLE with mem_read or mem_write high, or when state is ACCESS; low otherwise.
REQ-022 mem_req SHALL be high only in ACCESS; mem_we, mem_addr and mem_wdata SHALL stay stable throughout ACCESS.
REQ-023 In ACCESS with mem_ack=1, SHALL capture mem_rdata into rdata_out for reads, hold rdata_out unchanged for writes, and enter DONE.
REQ-024 DONE SHALL last exactly one cycle, with stall=0, rdata_valid=1 for reads and 0 for writes; state SHALL then return to IDLE.
REQ-025 SHALL ignore mem_read and mem_write in DONE, because EX/MEM advances in that cycle.
REQ-026 SHALL ignore mem_ack in IDLE and DONE.
REQ-027 Latency: when mem_ack arrives in the first ACCESS cycle, stall SHALL be high for exactly 2 cycles; each additional wait cycle SHALL add 1.
REQ-028 Back-to-back accesses SHALL each pass through IDLE, giving a minimum issue interval of 3 cycles.

Reset
REQ-029 On rst=1 at a posedge, from any state including mid-ACCESS, SHALL set state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata_out=0, rdata_valid=0 and err=0, with the timeout counter cleared.
REQ-030 stall SHALL follow REQ-021 in the cycle after reset.

Configuration
REQ-031 Macro MEM_TIMEOUT_EN SHALL compile in an 8-bit ACCESS cycle counter, cleared on ACCESS entry.
REQ-032 With MEM_TIMEOUT_EN: when the counter reaches TIMEOUT_CYCLES without mem_ack, SHALL drop mem_req, set err=1 (sticky until rst), load rdata_out=0, and enter DONE with rdata_valid=1 for reads.
REQ-033 Without MEM_TIMEOUT_EN: SHALL omit the counter, wait in ACCESS indefinitely, and tie err to 0.

Verification
REQ-034 Load: mem_read=1, addr 0x10; mem_ack on first ACCESS cycle with rdata 0xCAFE0001 -> stall high 2 cycles, mem_req 1 cycle, rdata_out=0xCAFE0001, rdata_valid 1 cycle.
REQ-035 Store: mem_write=1, addr 0x20, data 0x12345678; ack after 3 wait cycles -> mem_we=1, mem_addr/mem_wdata stable for 4 ACCESS cycles, stall 5 cycles, rdata_valid=0.
REQ-036 Back-to-back: load then store with immediate acks -> accesses exactly 3 cycles apart, no double issue in DONE.
REQ-037 Reset mid-operation: rst pulsed during ACCESS cycle 2 -> next cycle IDLE, mem_req=0, all outputs at reset values.
REQ-038 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ack never asserted -> mem_req high 4 cycles, err=1, rdata_out=0, rdata_valid pulse; err stays 1 until rst.
REQ-039 Read and write both high, with a spurious mem_ack in IDLE -> access performed as write, spurious ack ignored.
